// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO. A three-word
//            register window (TXDATA, STATUS, CTRL) sits at BASE_ADDR; bytes
//            stored to TXDATA are queued and serialised on txd, CLK_DIV clock
//            cycles per bit, with back-to-back frames when data is waiting.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1   single clock, rising edge
//   rst       in   1   synchronous active-high reset
//   io_addr   in  32   processor data address
//   io_wdata  in  32   processor store data
//   io_bwe    in   4   byte write enables (each asserted cycle is one store)
//   io_sel    out  1   address falls inside the register window
//   io_rdata  out 32   read data of the addressed register (0 when !io_sel)
//   txd       out  1   serial line, idle high
// Register map
//   0x0 TXDATA  W   byte lane 0 pushed into the FIFO, reads 0
//   0x4 STATUS  R   [0] full [1] empty [2] busy [3] overflow (W1C) [7:4] count
//   0x8 CTRL    RW  [0] enable
// ============================================================================
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          CLK_DIV    = 234,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_bwe,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic        txd
);

  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_DEPTH    = C_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_e               state_q,  state_d;
  logic [C_DIV_W-1:0]   div_q,    div_d;
  logic [2:0]           bit_q,    bit_d;
  logic [7:0]           shift_q,  shift_d;
  logic                 txd_q,    txd_d;
  logic [C_CNT_W-1:0]   count_q,  count_d;
  logic [C_PTR_W-1:0]   wptr_q,   wptr_d;
  logic [C_PTR_W-1:0]   rptr_q,   rptr_d;
  logic                 ovf_q,    ovf_d;
  logic                 enable_q, enable_d;
  logic [7:0]           mem_q [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic [1:0]  w_off;
  logic        w_push;
  logic        w_push_ok;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_ctrl_wr;
  logic        w_tick;
  logic [31:0] w_cnt_ext;

  assign w_off  = io_addr[3:2];
  // Offset 0xC lies inside the 16-byte aligned block but is not a register.
  assign io_sel = (io_addr[31:4] == BASE_ADDR[31:4]) && (w_off != 2'b11);

  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);
  assign w_busy  = (state_q != S_IDLE);

  assign w_push    = io_sel && (w_off == 2'b00) && io_bwe[0];
  // A pop in the same cycle frees the head slot, so a push to a full FIFO
  // still lands (the tail slot is the head slot being read out).
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ovf_clr = io_sel && (w_off == 2'b01) && io_bwe[0] && io_wdata[3];
  assign w_ctrl_wr = io_sel && (w_off == 2'b10) && io_bwe[0];

  assign w_tick    = (div_q == C_DIV_LAST);
  assign w_cnt_ext = 32'(count_q);

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    io_rdata = 32'h0;
    if (io_sel) begin
      case (w_off)
        2'b01:   io_rdata = {24'h0, w_cnt_ext[3:0], ovf_q, w_busy, w_empty, w_full};
        2'b10:   io_rdata = {31'h0, enable_q};
        default: io_rdata = 32'h0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM: next state, bit timing, pop request and line level
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    w_pop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_q && !w_empty) begin
          w_pop   = 1'b1;
          shift_d = mem_q[rptr_q];
          div_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          div_d = '0;
          // Chain straight into the next start bit so frames abut.
          if (enable_q && !w_empty) begin
            w_pop   = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered so txd is registered
    // without an extra cycle of delay.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO bookkeeping and control registers
  // --------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q + C_CNT_W'(w_push_ok) - C_CNT_W'(w_pop);
    wptr_d   = w_push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = w_pop     ? rptr_q + 1'b1 : rptr_q;
    // Set has priority over a same-cycle clear.
    ovf_d    = w_ovf_set ? 1'b1 : (w_ovf_clr ? 1'b0 : ovf_q);
    enable_d = w_ctrl_wr ? io_wdata[0] : enable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      enable_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      enable_q <= enable_d;
    end
  end

  // Storage carries no reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wptr_q] <= io_wdata[7:0];
    end
  end

  assign txd = txd_q;

  // Bits of the bus that carry no meaning for this peripheral.
  logic w_unused;
  assign w_unused = ^{io_wdata[31:8], io_addr[1:0], io_bwe[3:1], w_cnt_ext[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_mmio
// Purpose  : Directed self-checking bench for uart_tx_mmio (CLK_DIV=4,
//            FIFO_DEPTH=8). Expected bytes are queued when pushed and checked
//            against frames decoded from txd.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;

  logic        clk;
  logic        rst;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_bwe;
  logic        io_sel;
  logic [31:0] io_rdata;
  logic        txd;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb[$];
  logic       mon_en;

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_bwe   (io_bwe),
    .io_sel   (io_sel),
    .io_rdata (io_rdata),
    .txd      (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the store takes effect at the following posedge
  // and the task returns at the negedge after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    io_addr  = a;
    io_wdata = d;
    io_bwe   = be;
    @(negedge clk);
    io_bwe   = 4'h0;
    io_addr  = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    io_addr = a;
    #1;
    d = io_rdata;
  endtask

  // --------------------------------------------------------------------------
  // Frame decoder / scoreboard consumer (samples on negedge)
  // --------------------------------------------------------------------------
  initial begin
    int         q;
    logic       prev;
    logic [7:0] acc;
    logic [7:0] exp_b;
    q    = 0;
    prev = 1'b1;
    acc  = 8'h0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        q = 0;
      end else if (q == 0) begin
        if (prev && !txd) q = 1;
      end else begin
        if (q == 2) chk("mon_start_bit", txd, 1'b0);
        if (q >= 6 && q <= 34 && ((q - 6) % 4) == 0) acc[(q - 6) / 4] = txd;
        if (q == 38) begin
          chk("mon_stop_bit", txd, 1'b1);
          if (sb.size() == 0) begin
            chk("mon_unexpected_frame", 64'(acc), 64'h1FF);
          end else begin
            exp_b = sb.pop_front();
            chk("mon_frame_byte", acc, exp_b);
          end
        end
        q = (q == 39) ? 0 : q + 1;
      end
      prev = txd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] st;
    logic [39:0] got40;
    logic [39:0] exp40;
    logic [7:0]  b;
    int          run;
    int          maxrun;
    logic        all_high;
    logic        found;

    rst      = 1'b1;
    io_addr  = 32'h0;
    io_wdata = 32'h0;
    io_bwe   = 4'h0;
    mon_en   = 1'b1;

    // ---------------- reset state -----------------------------------------
    repeat (2) @(negedge clk);
    rd(A_ST, st);
    chk("sel_during_reset", io_sel, 1'b1);
    chk("status_during_reset", st, 32'h2);
    @(negedge clk);
    rst = 1'b0;
    chk("txd_reset", txd, 1'b1);
    rd(A_ST, st);
    chk("status_reset", st, 32'h2);
    rd(A_CT, st);
    chk("ctrl_reset", st, 32'h1);
    rd(A_TX, st);
    chk("txdata_reads_zero", st, 32'h0);

    // ---------------- single frame 0x55, exact waveform -------------------
    sb.push_back(8'h55);
    wr(A_TX, 32'h0000_0055, 4'h1);
    chk("txd_idle_at_push", txd, 1'b1);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      got40[j-1] = txd;
      if (j <= 4)       exp40[j-1] = 1'b0;
      else if (j <= 36) exp40[j-1] = (((j - 5) / 4) % 2 == 0) ? 1'b1 : 1'b0;
      else              exp40[j-1] = 1'b1;
    end
    chk("frame_55_waveform", got40, exp40);
    @(negedge clk);
    rd(A_ST, st);
    chk("status_after_frame", st, 32'h2);

    // ---------------- overflow with enable=0, then burst ------------------
    wr(A_CT, 32'h0, 4'h1);
    rd(A_CT, st);
    chk("ctrl_disabled", st, 32'h0);
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: b = 8'h55; 1: b = 8'h15; 2: b = 8'h45; 3: b = 8'h51;
        4: b = 8'h11; 5: b = 8'h05; 6: b = 8'h41; 7: b = 8'h54;
        default: b = 8'h7F;
      endcase
      if (i < 8) sb.push_back(b);
      io_addr  = A_TX;
      io_wdata = {24'h0, b};
      io_bwe   = 4'h1;
      @(negedge clk);
    end
    io_bwe = 4'h0;
    rd(A_ST, st);
    chk("status_overflow_full", st, 32'h89);
    wr(A_ST, 32'h8, 4'h1);
    rd(A_ST, st);
    chk("status_ovf_cleared", st, 32'h81);
    wr(A_CT, 32'h1, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    chk("burst_start_seen", found, 1'b1);
    run    = 0;
    maxrun = 0;
    for (int j = 0; j < 320; j++) begin
      if (j > 0) @(negedge clk);
      if (txd === 1'b1) run++;
      else              run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("burst_max_high_run", 64'(maxrun), 64'd4);
    @(negedge clk);
    rd(A_ST, st);
    chk("status_after_burst", st, 32'h2);
    chk("sb_empty_after_burst", 64'(sb.size()), 64'd0);

    // ---------------- push on the STOP->START pop edge while full ---------
    for (int i = 0; i < 9; i++) begin
      b = 8'hA0 + 8'(i);
      sb.push_back(b);
      io_addr  = A_TX;
      io_wdata = {24'h0, b};
      io_bwe   = 4'h1;
      @(negedge clk);
    end
    io_bwe = 4'h0;
    repeat (32) @(negedge clk);
    rd(A_ST, st);
    chk("full_before_pop_push", st, 32'h85);
    sb.push_back(8'h3C);
    wr(A_TX, 32'h0000_003C, 4'h1);
    rd(A_ST, st);
    chk("full_after_pop_push", st, 32'h85);
    found = 1'b0;
    for (int i = 0; i < 450 && !found; i++) begin
      @(negedge clk);
      rd(A_ST, st);
      if (st === 32'h2) found = 1'b1;
    end
    chk("drain_after_pop_push", found, 1'b1);
    chk("sb_empty_after_pop_push", 64'(sb.size()), 64'd0);

    // ---------------- reset during DATA bit 3 -----------------------------
    mon_en = 1'b0;
    wr(A_TX, 32'h0000_00F7, 4'h1);
    wr(A_TX, 32'h0000_0012, 4'h1);
    repeat (17) @(negedge clk);
    chk("txd_bit3_before_reset", txd, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("txd_after_abort", txd, 1'b1);
    rd(A_ST, st);
    chk("status_after_abort", st, 32'h2);
    all_high = 1'b1;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (txd !== 1'b1) all_high = 1'b0;
    end
    chk("no_frame_after_abort", all_high, 1'b1);
    mon_en = 1'b1;

    // ---------------- out-of-window accesses ------------------------------
    rd(BASE + 32'hC, st);
    chk("sel_offset_c", io_sel, 1'b0);
    chk("rdata_offset_c", st, 32'h0);
    rd(BASE - 32'h4, st);
    chk("sel_below_base", io_sel, 1'b0);
    chk("rdata_below_base", st, 32'h0);
    wr(BASE + 32'hC, 32'h0000_00AA, 4'hF);
    wr(BASE - 32'h4, 32'h0000_00AA, 4'hF);
    wr(BASE + 32'h10, 32'h0000_00AA, 4'hF);
    wr(BASE + 32'h18, 32'h0, 4'hF);
    wr(A_TX, 32'h0000_00AA, 4'hE);
    all_high = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (txd !== 1'b1) all_high = 1'b0;
    end
    chk("no_tx_from_stray_writes", all_high, 1'b1);
    rd(A_ST, st);
    chk("status_after_stray_writes", st, 32'h2);
    rd(A_CT, st);
    chk("ctrl_after_stray_writes", st, 32'h1);

    // ---------------- disable during START bit ----------------------------
    sb.push_back(8'h6B);
    sb.push_back(8'hC3);
    wr(A_TX, 32'h0000_006B, 4'h1);
    wr(A_TX, 32'h0000_00C3, 4'h1);
    wr(A_CT, 32'h0, 4'h1);
    rd(A_ST, st);
    chk("status_disable_in_start", st, 32'h14);
    repeat (38) @(negedge clk);
    rd(A_ST, st);
    chk("status_last_stop_cycle", st, 32'h14);
    @(negedge clk);
    rd(A_ST, st);
    chk("status_held_after_frame", st, 32'h10);
    all_high = 1'b1;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (txd !== 1'b1) all_high = 1'b0;
    end
    chk("line_idle_while_disabled", all_high, 1'b1);
    rd(A_ST, st);
    chk("count_held_while_disabled", st, 32'h10);
    chk("sb_one_left", 64'(sb.size()), 64'd1);
    wr(A_CT, 32'h1, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      rd(A_ST, st);
      if (st === 32'h2) found = 1'b1;
    end
    chk("drain_after_reenable", found, 1'b1);
    chk("sb_empty_final", 64'(sb.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
